// File: rtl/axis_ask_uart_tx.sv
// axis_ask_uart_tx: AXI-Stream byte sink -> FIFO -> 8N1 UART serializer -> on/off-keyed
// carrier drive for the ASK link front-end. Single clock domain, async active-low reset.
// Optional build macro AXIS_ASK_UART_TX_RAW_EN adds a 'tx' output carrying the registered
// UART line, cycle-aligned with ask_tx (tx=0 exactly when the carrier is on).
module axis_ask_uart_tx #(
    parameter int TX_SIZE     = 4,   // log2 of FIFO depth
    parameter int clkdiv_tx   = 12,  // clocks per UART bit, >= 2
    parameter int CARRIER_DIV = 1    // clocks per carrier half-period, >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_tdata,
    input  logic       i_tvalid,
    output logic       i_tready,
    output logic [1:0] ask_tx
`ifdef AXIS_ASK_UART_TX_RAW_EN
    ,
    output logic       tx
`endif
);

    localparam int DEPTH = 2 ** TX_SIZE;
    localparam int CW    = (clkdiv_tx > 1) ? $clog2(clkdiv_tx) : 1;
    localparam int CDW   = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam int PW    = TX_SIZE + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and wrapping pointers (extra MSB distinguishes full from empty)
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ready_q, ready_d;
    logic          push, pop, empty, full_d;
    logic [7:0]    mem_rd;

    // Serializer
    state_t        state_q, state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          baud_end;
    logic          line_c;

    // Carrier generator / output register
    logic [1:0]     ask_q, ask_d;
    logic           phase_q, phase_d;
    logic [CDW-1:0] car_cnt_q, car_cnt_d;

    assign push     = i_tvalid & ready_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign mem_rd   = mem[rd_ptr_q[TX_SIZE-1:0]];
    assign baud_end = (baud_cnt_q == CW'(clkdiv_tx - 1));

    // FIFO pointer update; ready is registered from the post-update occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
        full_d   = (wr_ptr_d[TX_SIZE] != rd_ptr_d[TX_SIZE]) &&
                   (wr_ptr_d[TX_SIZE-1:0] == rd_ptr_d[TX_SIZE-1:0]);
        ready_d  = ~full_d;
    end

    // FIFO data write; storage is not reset, only the pointers are
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[TX_SIZE-1:0]] <= i_tdata;
        end
    end

    // FIFO pointer and ready registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
        end
    end

    // Serializer next state: frame timing, FIFO pop and the unregistered line level
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + CW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        line_c     = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_rd;
                    state_d = S_START;
                end
            end
            S_START: begin
                line_c = 1'b0;
                if (baud_end) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = 3'd0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                line_c = shift_q[0];
                if (baud_end) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                line_c = 1'b1;
                if (baud_end) begin
                    baud_cnt_d = '0;
                    // Back-to-back frames: next start bit follows the stop bit directly
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_rd;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                baud_cnt_d = '0;
            end
        endcase
    end

    // Serializer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // Carrier keying: mark turns carrier off and rewinds the phase so each burst starts at 2'b01
    always_comb begin
        ask_d     = 2'b00;
        phase_d   = 1'b0;
        car_cnt_d = '0;
        if (!line_c) begin
            ask_d = phase_q ? 2'b10 : 2'b01;
            if (car_cnt_q == CDW'(CARRIER_DIV - 1)) begin
                car_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                car_cnt_d = car_cnt_q + CDW'(1);
                phase_d   = phase_q;
            end
        end
    end

    // Carrier and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ask_q     <= 2'b00;
            phase_q   <= 1'b0;
            car_cnt_q <= '0;
        end else begin
            ask_q     <= ask_d;
            phase_q   <= phase_d;
            car_cnt_q <= car_cnt_d;
        end
    end

    assign i_tready = ready_q;
    assign ask_tx   = ask_q;

`ifdef AXIS_ASK_UART_TX_RAW_EN
    logic tx_q;

    // Raw UART line, registered alongside ask_q so both change on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q <= 1'b1;
        end else begin
            tx_q <= line_c;
        end
    end

    assign tx = tx_q;
`endif

endmodule

// File: tb/tb_axis_ask_uart_tx.sv
// Bench for axis_ask_uart_tx (TX_SIZE=4, clkdiv_tx=12, CARRIER_DIV=1).
`timescale 1ns/1ps
module tb_axis_ask_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i_tdata = 8'h00;
    logic       i_tvalid = 1'b0;
    logic       i_tready;
    logic [1:0] ask_tx;
`ifdef AXIS_ASK_UART_TX_RAW_EN
    logic       tx;
`endif

    axis_ask_uart_tx #(
        .TX_SIZE    (4),
        .clkdiv_tx  (12),
        .CARRIER_DIV(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_tdata (i_tdata),
        .i_tvalid(i_tvalid),
        .i_tready(i_tready),
        .ask_tx  (ask_tx)
`ifdef AXIS_ASK_UART_TX_RAW_EN
        ,
        .tx      (tx)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_edge  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // {stop, data[7:0], start}, bit 0 transmitted first
    } vec_t;
    vec_t vecs[6];

    logic [9:0] exp_q[$];
    logic       line_w;
    assign line_w = (ask_tx == 2'b00);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s got=%0h required=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Frame monitor: detect start, sample each bit mid-slot, compare against scoreboard
    bit         mon_busy = 1'b0;
    int         mon_start = 0;
    int         mon_last_start = 0;
    int         frames_seen = 0;
    int         mon_off;
    int         mon_k;
    logic [9:0] mon_bits;
    logic [9:0] mon_exp;

    always @(negedge clk) begin
        if (!rst) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (line_w == 1'b0) begin
                mon_busy       = 1'b1;
                mon_start      = cyc;
                mon_last_start = cyc;
            end
        end else begin
            mon_off = cyc - mon_start;
            if (mon_off >= 6 && ((mon_off - 6) % 12) == 0) begin
                mon_k = (mon_off - 6) / 12;
                mon_bits[mon_k] = line_w;
                if (mon_k == 9) begin
                    mon_busy = 1'b0;
                    frames_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame got=%03h required=none", mon_bits);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("frame", 32'(mon_bits), 32'(mon_exp));
                        $display("frame %0d start=%0d data=%02h expected=%02h",
                                 frames_seen, mon_start, mon_bits[8:1], mon_exp[8:1]);
                    end
                end
            end
        end
    end

    // Carrier checker: bursts start at 01 and alternate every clock; raw line mirrors carrier-off
    logic [1:0] prev_ask = 2'b00;
    logic [1:0] exp_ask;
    always @(negedge clk) begin
        if (!rst) begin
            prev_ask = 2'b00;
        end else begin
            if (ask_tx != 2'b00) begin
                exp_ask = (prev_ask == 2'b01) ? 2'b10 : 2'b01;
                chk("carrier", 32'(ask_tx), 32'(exp_ask));
            end
`ifdef AXIS_ASK_UART_TX_RAW_EN
            chk("tx_align", 32'(tx), 32'(line_w));
`endif
            prev_ask = ask_tx;
        end
    end

    task automatic send(input logic [7:0] d, input logic [9:0] fr, input bit expect_it);
        int w;
        w = 0;
        @(negedge clk);
        while (i_tready !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (i_tready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=ready_low required=ready_high");
        end else begin
            i_tdata  = d;
            i_tvalid = 1'b1;
            hs_edge  = cyc + 1;
            if (expect_it) exp_q.push_back(fr);
            @(negedge clk);
            i_tvalid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || mon_busy) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d_pending required=0", exp_q.size());
        end
    endtask

    task automatic count_run(input bit on, input int limit, output int n);
        n = 0;
        while (((ask_tx != 2'b00) == on) && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n_run;
    int wcnt;
    int frames_before;
    logic [7:0] bd;

    initial begin
        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'hA3, 10'b1101000110};
        vecs[2] = '{8'h01, 10'b1000000010};
        vecs[3] = '{8'h80, 10'b1100000000};
        vecs[4] = '{8'h3C, 10'b1001111000};
        vecs[5] = '{8'hFF, 10'b1111111110};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ask", 32'(ask_tx), 32'h0);
        chk("rst_ready", 32'(i_tready), 32'h1);
`ifdef AXIS_ASK_UART_TX_RAW_EN
        chk("rst_tx", 32'(tx), 32'h1);
`endif
        rst = 1'b1;

        // Idle with no input
        repeat (50) begin
            @(negedge clk);
            chk("idle_ask", 32'(ask_tx), 32'h0);
            chk("idle_ready", 32'(i_tready), 32'h1);
        end

        // Single 0x55 frame and handshake-to-carrier latency
        send(8'h55, 10'b1010101010, 1'b1);
        wait_drain(400);
        chk("latency", 32'(mon_last_start - hs_edge), 32'd2);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].frame, 1'b1);
        end
        wait_drain(1500);

        // 0x00 then 0xFF back-to-back: 108 on, 12 off, 12 on, then long off
        repeat (20) @(negedge clk);
        send(8'h00, 10'b1000000000, 1'b1);
        send(8'hFF, 10'b1111111110, 1'b1);
        wcnt = 0;
        while (line_w && wcnt < 300) begin
            @(negedge clk);
            wcnt++;
        end
        count_run(1'b1, 400, n_run);
        chk("run_00_carrier", 32'(n_run), 32'd108);
        count_run(1'b0, 400, n_run);
        chk("run_00_stop", 32'(n_run), 32'd12);
        count_run(1'b1, 400, n_run);
        chk("run_ff_start", 32'(n_run), 32'd12);
        count_run(1'b0, 200, n_run);
        chk("run_ff_off_ge108", 32'(n_run >= 108), 32'h1);
        wait_drain(400);

        // Burst of 18 bytes, one per clock: 17 accepted, 18th refused
        repeat (20) @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            bd       = 8'h30 + 8'(i);
            i_tdata  = bd;
            i_tvalid = 1'b1;
            chk("burst_ready", 32'(i_tready), 32'(i < 17));
            if (i < 17) exp_q.push_back({1'b1, bd, 1'b0});
            @(negedge clk);
        end
        i_tvalid = 1'b0;
        wait_drain(17 * 120 + 400);
        repeat (10) @(negedge clk);
        chk("burst_ready_after", 32'(i_tready), 32'h1);

        // Reset in the middle of a frame's data bits with more bytes queued
        send(8'hA5, 10'b0, 1'b0);
        send(8'h5A, 10'b0, 1'b0);
        send(8'hC3, 10'b0, 1'b0);
        wcnt = 0;
        while (line_w && wcnt < 300) begin
            @(negedge clk);
            wcnt++;
        end
        repeat (40) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ask", 32'(ask_tx), 32'h0);
        chk("midrst_ready", 32'(i_tready), 32'h1);
`ifdef AXIS_ASK_UART_TX_RAW_EN
        chk("midrst_tx", 32'(tx), 32'h1);
`endif
        exp_q.delete();
        frames_before = frames_seen;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (400) @(negedge clk);
        chk("no_residual_frames", 32'(frames_seen), 32'(frames_before));
        chk("post_rst_ask", 32'(ask_tx), 32'h0);
        chk("post_rst_ready", 32'(i_tready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
